int2fp_seq: RTL and testbench

- Multi-cycle converter from a 32-bit two's-complement integer to an IEEE-754 single-precision value.
- Normalizes with a one-bit-per-cycle left shifter, then rounds and packs the result.
- Performs the reverse of the fixed-point/integer extraction path, so integer quantities can be fed back into the float datapath.
- Uses a start/busy/done handshake with one conversion in flight at a time.

---
 rtl/int2fp_seq.sv | 127 ++++++++++++
 tb/tb_int2fp_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2fp_seq.sv
// Sequential int32 -> IEEE-754 single converter: one-bit-per-cycle normalizer, then round and pack.
// Define INT2FP_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
//
// state   | meaning
// IDLE    | waiting for start; zero operands complete here in one cycle
// NORM    | shift magnitude left until its MSB is set, decrementing the exponent
// ROUND   | round (or truncate), pack and pulse done
module int2fp_seq #(
   parameter int BIAS = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] int_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] fp_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_NORM  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;

   localparam logic [7:0] EXP_TOP = 8'(BIAS + 31);

   logic [1:0]  state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic        done_q, done_d;
   logic [31:0] fp_q, fp_d;

   logic [31:0] mag_abs;
   logic [22:0] frac_rnd;
   logic [7:0]  exp_rnd;

   // -2^31 negates to itself, which is exactly the unsigned magnitude wanted
   assign mag_abs = int_in[31] ? (~int_in + 32'd1) : int_in;

`ifdef INT2FP_RNE_EN
   logic        guard_bit;
   logic        sticky_bit;
   logic        lsb_bit;
   logic        round_up;
   logic [23:0] frac_sum;

   always_comb begin
      guard_bit  = mag_q[7];
      sticky_bit = |mag_q[6:0];
      lsb_bit    = mag_q[8];
      round_up   = guard_bit & (sticky_bit | lsb_bit);
      frac_sum   = {1'b0, mag_q[30:8]} + {23'd0, round_up};
      // a carry out of the fraction leaves it zero and bumps the exponent
      frac_rnd   = frac_sum[22:0];
      exp_rnd    = exp_q + {7'd0, frac_sum[23]};
   end
`else
   always_comb begin
      frac_rnd = mag_q[30:8];
      exp_rnd  = exp_q;
   end
`endif

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      done_d  = 1'b0;
      fp_d    = fp_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (int_in == 32'd0) begin
                  fp_d   = 32'd0;
                  done_d = 1'b1;
               end else begin
                  sign_d  = int_in[31];
                  mag_d   = mag_abs;
                  exp_d   = EXP_TOP;
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
            if (mag_q[31]) begin
               state_d = S_ROUND;
            end else begin
               mag_d = {mag_q[30:0], 1'b0};
               exp_d = exp_q - 8'd1;
            end
         end
         S_ROUND: begin
            fp_d    = {sign_q, exp_rnd, frac_rnd};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mag_q   <= 32'd0;
         exp_q   <= 8'd0;
         sign_q  <= 1'b0;
         done_q  <= 1'b0;
         fp_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         done_q  <= done_d;
         fp_q    <= fp_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign fp_out = fp_q;

endmodule

// File: tb/tb_int2fp_seq.sv
// Bench for int2fp_seq: vector table plus random operands, scoreboarded against a remainder-based model.
// Expectations follow INT2FP_RNE_EN the same way the design does.
module tb_int2fp_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] int_in;
   logic        busy;
   logic        done;
   logic [31:0] fp_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] e_trunc;
      logic [31:0] e_rne;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] fp;
      int          acc;
      int          lat;
   } sb_t;

   vec_t vecs[11];
   sb_t  sbq[$];

   int2fp_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .int_in (int_in),
      .busy   (busy),
      .done   (done),
      .fp_out (fp_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ref_fp(input logic [31:0] x);
      logic [31:0] m;
      logic [63:0] f;
      logic [7:0]  e;
      int          p;
`ifdef INT2FP_RNE_EN
      logic [63:0] rem;
      logic [63:0] half;
`endif
      if (x == 32'd0) return 32'd0;
      m = x[31] ? (32'd0 - x) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      e = 8'(127 + p);
      if (p <= 23) begin
         f = 64'(m) << (23 - p);
      end else begin
         f = 64'(m) >> (p - 23);
`ifdef INT2FP_RNE_EN
         rem  = 64'(m) & ((64'd1 << (p - 23)) - 64'd1);
         half = 64'd1 << (p - 24);
         if (rem > half || (rem == half && f[0])) f = f + 64'd1;
`endif
         if (f[24]) begin
            f = f >> 1;
            e = e + 8'd1;
         end
      end
      return {x[31], e, f[22:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] x);
      logic [31:0] m;
      int          p;
      if (x == 32'd0) return 0;
      m = x[31] ? (32'd0 - x) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      return 33 - p;
   endfunction

   // scoreboard: pop on every done, compare value, latency and busy duration
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=%h required=no_done", fp_out);
            end else begin
               e = sbq.pop_front();
               check("fp_out", fp_out, e.fp);
               check("latency", 32'(cyc - e.acc), 32'(e.lat));
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int w = 0;
      while (busy && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] e, input int lat);
      sb_t s;
      wait_idle();
      start  = 1'b1;
      int_in = x;
      s.fp   = e;
      s.acc  = cyc + 1;
      s.lat  = lat;
      sbq.push_back(s);
      @(negedge clk);
      start  = 1'b0;
      int_in = $urandom;
   endtask

   task automatic drain();
      int w = 0;
      while ((sbq.size() != 0 || busy) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("drain_empty", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x;
      sb_t s;
      int n;

      vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 33};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000, 33};
      vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
      vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000, 2};
      vecs[4]  = '{32'h7FFF_FFFF, 32'h4EFF_FFFF, 32'h4F00_0000, 3};
      vecs[5]  = '{32'd16777219,  32'h4B80_0001, 32'h4B80_0002, 9};
      vecs[6]  = '{32'h0000_0002, 32'h4000_0000, 32'h4000_0000, 32};
      vecs[7]  = '{32'd100,       32'h42C8_0000, 32'h42C8_0000, 27};
      vecs[8]  = '{32'hFFFF_FF9C, 32'hC2C8_0000, 32'hC2C8_0000, 27};
      vecs[9]  = '{32'd16777217,  32'h4B80_0000, 32'h4B80_0000, 9};
      vecs[10] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};

      rst    = 1'b1;
      start  = 1'b0;
      int_in = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_fp_out", fp_out, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
`ifdef INT2FP_RNE_EN
         drive(vecs[i].x, vecs[i].e_rne, vecs[i].lat);
`else
         drive(vecs[i].x, vecs[i].e_trunc, vecs[i].lat);
`endif
      end
      drain();

      for (int i = 0; i < 24; i++) begin
         x = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
         drive(x, ref_fp(x), ref_lat(x));
      end
      drain();

      // start held high with a changing operand: only the first value converts
      wait_idle();
      start  = 1'b1;
      int_in = 32'd5;
      s.fp   = 32'h40A0_0000;
      s.acc  = cyc + 1;
      s.lat  = 31;
      sbq.push_back(s);
      n = 0;
      do begin
         @(negedge clk);
         int_in = $urandom | 32'h0000_0100;
         n++;
      end while (busy && n < 60);
      start = 1'b0;
      check("hold_terminated", {31'd0, busy}, 32'd0);
      drain();

      // back-to-back: the next start lands in the done cycle
      drive(32'd1, 32'h3F80_0000, 33);
      wait_idle();
      check("b2b_done_at_accept", {31'd0, done}, 32'd1);
      drive(32'd2, 32'h4000_0000, 32);
      drain();

      // reset in the middle of a conversion abandons it
      start  = 1'b1;
      int_in = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("midop_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midop_rst_busy", {31'd0, busy}, 32'd0);
      check("midop_rst_done", {31'd0, done}, 32'd0);
      check("midop_rst_fp_out", fp_out, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      // reset and start together: reset wins
      rst    = 1'b1;
      start  = 1'b1;
      int_in = 32'd5;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      check("rst_start_stays_idle", {31'd0, busy}, 32'd0);

      drive(32'd2, 32'h4000_0000, 32);
      drive(32'hFFFF_FFFF, 32'hBF80_0000, 33);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
